// File: rtl/pipe_pkg.sv
// Shared types and field indices for the five-stage pipeline.
// Imported by the hazard controller and its helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_t;

  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline event statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count events, clear on reset, hold at the ceiling
  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencing for the five-stage pipe.
// Mealy outputs from state and live hazard inputs.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             ex_mem_branch,
  input  logic             ex_mem_zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             pipe_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pc_src,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] wait_count
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] LAST = WCW'(MAX_WAIT - 1);

  state_t         state;
  logic [WCW-1:0] wait_cnt;

  logic lu_hazard;
  logic br_taken;
  logic live;
  logic freeze;
  logic take;
  logic lu_stall;

  assign lu_hazard = id_ex_memread
                   && (id_ex_rt != '0)
                   && ((id_ex_rt == if_id_rs)
                    || (if_id_uses_rt
                     && (id_ex_rt == if_id_rt)));

  assign br_taken = ex_mem_branch && ex_mem_zero;

  assign live     = reset && (state != HALT);
  assign freeze   = live && !mem_ready;
  assign take     = live && mem_ready && br_taken;
  assign lu_stall = live && mem_ready
                  && !br_taken && lu_hazard;

  // next state and consecutive not-ready tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        RUN, MEM_WAIT: begin
          if (!mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
            state    <= (wait_cnt == LAST)
                      ? HALT : MEM_WAIT;
          end else begin
            wait_cnt <= '0;
            state    <= RUN;
          end
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  // same-cycle pipeline control from state and hazards
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    pipe_stall   = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_src       = 1'b0;
    halted       = 1'b0;
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      pipe_stall   = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (state == HALT) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_stall  = 1'b1;
      halted      = 1'b1;
    end else begin
      unique case (1'b1)
        freeze: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_stall  = 1'b1;
        end
        take: begin
          pc_src       = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end
        lu_stall: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (lu_stall),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk   (clk),
    .reset (reset),
    .inc   (take),
    .count (flush_count)
  );

  sat_counter #(.W(CNT_W)) u_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (freeze),
    .count (wait_count)
  );

endmodule
